multicycle_control: RTL and testbench

- Main control FSM for the multicycle MIPS datapath.
- Sequences instruction fetch, decode, execute, memory and writeback.
- Drives mux selects, write enables and ALU op class.
- Drives the `arith` select of the 16→32 sign-extension unit: 1 = sign-extend, 0 = zero-extend.
- Runs a request/ready handshake with the shared instruction/data memory.

---
 rtl/mips_ctrl_pkg.sv | 47 ++++
 rtl/mips_ext_decode.sv | 20 ++
 rtl/multicycle_control.sv | 174 +++++++++++++++++
 tb/tb_multicycle_control.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared constants for the multicycle MIPS control path: opcodes, FSM state
// encodings and the datapath select values driven by the controller.
package mips_ctrl_pkg;

    localparam int OP_WIDTH = 6;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [1:0] ALU_OP_ADD   = 2'd0;
    localparam logic [1:0] ALU_OP_SUB   = 2'd1;
    localparam logic [1:0] ALU_OP_FUNCT = 2'd2;
    localparam logic [1:0] ALU_OP_IMM   = 2'd3;

    localparam logic [1:0] ALU_SRC_B_REG    = 2'd0;
    localparam logic [1:0] ALU_SRC_B_FOUR   = 2'd1;
    localparam logic [1:0] ALU_SRC_B_IMM    = 2'd2;
    localparam logic [1:0] ALU_SRC_B_IMM_SH = 2'd3;

    localparam logic [1:0] PC_SRC_ALU    = 2'd0;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'd1;
    localparam logic [1:0] PC_SRC_JUMP   = 2'd2;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMRD    = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEMWR    = 4'd5,
        S_RTYPE_EX = 4'd6,
        S_RTYPE_WB = 4'd7,
        S_BR_EX    = 4'd8,
        S_IMM_EX   = 4'd9,
        S_IMM_WB   = 4'd10,
        S_JMP      = 4'd11
    } state_e;

endpackage

// File: rtl/mips_ext_decode.sv
// Opcode to extension-mode decoder: logical immediates (andi, ori) want a
// zero-extended immediate, everything else sign-extends.
module mips_ext_decode
    import mips_ctrl_pkg::*;
#(
    parameter int OP_W = 6
) (
    input  logic [OP_W-1:0] opcode_i,
    output logic            ext_arith_o
);

    // Zero-extend only for the logical immediate ops.
    always_comb begin
        ext_arith_o = 1'b1;
        if ((opcode_i == OP_ANDI) || (opcode_i == OP_ORI)) begin
            ext_arith_o = 1'b0;
        end
    end

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle MIPS datapath. Outputs are decoded from
// the current state, with memory-ready, branch-zero and opcode qualifiers.
module multicycle_control
    import mips_ctrl_pkg::*;
#(
    parameter int OP_W = 6
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [OP_W-1:0] opcode,
    input  logic            zero,
    input  logic            mem_ready,
    output logic            mem_req,
    output logic            mem_write,
    output logic            iord,
    output logic            ir_write,
    output logic            pc_write,
    output logic [1:0]      pc_src,
    output logic            reg_write,
    output logic            reg_dst,
    output logic            mem_to_reg,
    output logic            alu_src_a,
    output logic [1:0]      alu_src_b,
    output logic [1:0]      alu_op,
    output logic            ext_arith,
    output logic            illegal,
    output logic [3:0]      state_dbg
);

    state_e state_q;
    state_e state_d;
    logic   extArithDec;

    mips_ext_decode #(
        .OP_W (OP_W)
    ) u_ext_decode (
        .opcode_i    (opcode),
        .ext_arith_o (extArithDec)
    );

    // State register; reset returns the controller to instruction fetch.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and output decode; reset forces every output low that cycle.
    always_comb begin
        state_d    = state_q;
        mem_req    = 1'b0;
        mem_write  = 1'b0;
        iord       = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = PC_SRC_ALU;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = ALU_SRC_B_REG;
        alu_op     = ALU_OP_ADD;
        illegal    = 1'b0;
        ext_arith  = 1'b0;
        state_dbg  = 4'd0;

        if (reset) begin
            state_d = S_FETCH;
        end else begin
            ext_arith = extArithDec;
            state_dbg = state_q;
            case (state_q)
                S_FETCH: begin
                    mem_req   = 1'b1;
                    alu_src_b = ALU_SRC_B_FOUR;
                    if (mem_ready) begin
                        ir_write = 1'b1;
                        pc_write = 1'b1;
                        state_d  = S_DECODE;
                    end
                end
                S_DECODE: begin
                    alu_src_b = ALU_SRC_B_IMM_SH;
                    case (opcode)
                        OP_LW, OP_SW:                      state_d = S_MEMADR;
                        OP_RTYPE:                          state_d = S_RTYPE_EX;
                        OP_BEQ, OP_BNE:                    state_d = S_BR_EX;
                        OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI: state_d = S_IMM_EX;
                        OP_J:                              state_d = S_JMP;
                        default: begin
                            illegal = 1'b1;
                            state_d = S_FETCH;
                        end
                    endcase
                end
                S_MEMADR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = ALU_SRC_B_IMM;
                    if (opcode == OP_LW) begin
                        state_d = S_MEMRD;
                    end else if (opcode == OP_SW) begin
                        state_d = S_MEMWR;
                    end else begin
                        state_d = S_FETCH;
                    end
                end
                S_MEMRD: begin
                    mem_req = 1'b1;
                    iord    = 1'b1;
                    if (mem_ready) begin
                        state_d = S_MEM_WB;
                    end
                end
                S_MEM_WB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                    state_d    = S_FETCH;
                end
                S_MEMWR: begin
                    mem_req   = 1'b1;
                    mem_write = 1'b1;
                    iord      = 1'b1;
                    if (mem_ready) begin
                        state_d = S_FETCH;
                    end
                end
                S_RTYPE_EX: begin
                    alu_src_a = 1'b1;
                    alu_op    = ALU_OP_FUNCT;
                    state_d   = S_RTYPE_WB;
                end
                S_RTYPE_WB: begin
                    reg_write = 1'b1;
                    reg_dst   = 1'b1;
                    state_d   = S_FETCH;
                end
                S_BR_EX: begin
                    alu_src_a = 1'b1;
                    alu_op    = ALU_OP_SUB;
                    pc_src    = PC_SRC_ALUOUT;
                    if (opcode == OP_BEQ) begin
                        pc_write = zero;
                    end else if (opcode == OP_BNE) begin
                        pc_write = ~zero;
                    end
                    state_d = S_FETCH;
                end
                S_IMM_EX: begin
                    alu_src_a = 1'b1;
                    alu_src_b = ALU_SRC_B_IMM;
                    alu_op    = ALU_OP_IMM;
                    state_d   = S_IMM_WB;
                end
                S_IMM_WB: begin
                    reg_write = 1'b1;
                    state_d   = S_FETCH;
                end
                S_JMP: begin
                    pc_write = 1'b1;
                    pc_src   = PC_SRC_JUMP;
                    state_d  = S_FETCH;
                end
                default: begin
                    ext_arith = 1'b0;
                    state_dbg = 4'd0;
                    state_d   = S_FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for the multicycle control FSM: walks each instruction class
// through its states and compares the full output bundle every cycle.
module tb_multicycle_control;

    logic       clk;
    logic       reset;
    logic [5:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       mem_req;
    logic       mem_write;
    logic       iord;
    logic       ir_write;
    logic       pc_write;
    logic [1:0] pc_src;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       ext_arith;
    logic       illegal;
    logic [3:0] state_dbg;

    int checkCount;
    int errorCount;

    logic [20:0] outVec;

    multicycle_control #(
        .OP_W (6)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .opcode     (opcode),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .mem_req    (mem_req),
        .mem_write  (mem_write),
        .iord       (iord),
        .ir_write   (ir_write),
        .pc_write   (pc_write),
        .pc_src     (pc_src),
        .reg_write  (reg_write),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .ext_arith  (ext_arith),
        .illegal    (illegal),
        .state_dbg  (state_dbg)
    );

    // 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Whole output bundle packed in a fixed order for one-shot comparison.
    assign outVec = {mem_req, mem_write, iord, ir_write, pc_write, pc_src,
                     reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b,
                     alu_op, ext_arith, illegal, state_dbg};

    // Builds an expected bundle from hand-written field values.
    function automatic logic [20:0] pack(
        input logic       memReq,
        input logic       memWrite,
        input logic       iordV,
        input logic       irWrite,
        input logic       pcWrite,
        input logic [1:0] pcSrc,
        input logic       regWrite,
        input logic       regDst,
        input logic       memToReg,
        input logic       srcA,
        input logic [1:0] srcB,
        input logic [1:0] aluOp,
        input logic       ext,
        input logic       ill,
        input logic [3:0] st
    );
        return {memReq, memWrite, iordV, irWrite, pcWrite, pcSrc,
                regWrite, regDst, memToReg, srcA, srcB, aluOp, ext, ill, st};
    endfunction

    // Counts one comparison and reports it if observed differs from expected.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%06h, expected 0x%06h", tag, observed, expected);
        end
    endtask

    // Drives one cycle of inputs mid-period, then lets combinational outputs settle.
    task automatic applyStimulus(input logic rst, input logic [5:0] op,
                                 input logic z, input logic rdy);
        @(negedge clk);
        reset     = rst;
        opcode    = op;
        zero      = z;
        mem_ready = rdy;
        #1;
    endtask

    initial begin
        checkCount = 0;
        errorCount = 0;
        reset      = 1'b1;
        opcode     = 6'b101011;
        zero       = 1'b0;
        mem_ready  = 1'b0;

        // Reset state: everything low.
        applyStimulus(1, 6'b101011, 0, 0);
        checkOutput("reset.initial", outVec, pack(0,0,0,0,0,0,0,0,0,0,0,0,0,0,0));

        // sw up to MEMWR.
        applyStimulus(0, 6'b101011, 0, 1);
        checkOutput("sw.fetch", outVec, pack(1,0,0,1,1,0,0,0,0,0,1,0,1,0,0));
        applyStimulus(0, 6'b101011, 0, 1);
        checkOutput("sw.decode", outVec, pack(0,0,0,0,0,0,0,0,0,0,3,0,1,0,1));
        applyStimulus(0, 6'b101011, 0, 1);
        checkOutput("sw.memadr", outVec, pack(0,0,0,0,0,0,0,0,0,1,2,0,1,0,2));
        applyStimulus(0, 6'b101011, 0, 0);
        checkOutput("sw.memwr.wait", outVec, pack(1,1,1,0,0,0,0,0,0,0,0,0,1,0,5));

        // Reset for two cycles while MEMWR sees mem_ready.
        applyStimulus(1, 6'b101011, 0, 1);
        checkOutput("reset.memwr.c1", outVec, pack(0,0,0,0,0,0,0,0,0,0,0,0,0,0,0));
        applyStimulus(1, 6'b101011, 0, 1);
        checkOutput("reset.memwr.c2", outVec, pack(0,0,0,0,0,0,0,0,0,0,0,0,0,0,0));

        // FETCH waiting three cycles, then lw with ready always high.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 6'b100011, 0, 0);
            checkOutput($sformatf("fetch.wait%0d", i), outVec,
                        pack(1,0,0,0,0,0,0,0,0,0,1,0,1,0,0));
        end
        applyStimulus(0, 6'b100011, 0, 1);
        checkOutput("lw.fetch.ready", outVec, pack(1,0,0,1,1,0,0,0,0,0,1,0,1,0,0));
        applyStimulus(0, 6'b100011, 0, 1);
        checkOutput("lw.decode", outVec, pack(0,0,0,0,0,0,0,0,0,0,3,0,1,0,1));
        applyStimulus(0, 6'b100011, 0, 1);
        checkOutput("lw.memadr", outVec, pack(0,0,0,0,0,0,0,0,0,1,2,0,1,0,2));
        applyStimulus(0, 6'b100011, 0, 1);
        checkOutput("lw.memrd", outVec, pack(1,0,1,0,0,0,0,0,0,0,0,0,1,0,3));
        applyStimulus(0, 6'b100011, 0, 1);
        checkOutput("lw.memwb", outVec, pack(0,0,0,0,0,0,1,0,1,0,0,0,1,0,4));

        // beq taken.
        applyStimulus(0, 6'b000100, 1, 1);
        checkOutput("beq.fetch", outVec, pack(1,0,0,1,1,0,0,0,0,0,1,0,1,0,0));
        applyStimulus(0, 6'b000100, 1, 1);
        checkOutput("beq.decode", outVec, pack(0,0,0,0,0,0,0,0,0,0,3,0,1,0,1));
        applyStimulus(0, 6'b000100, 1, 1);
        checkOutput("beq.brex", outVec, pack(0,0,0,0,1,1,0,0,0,1,0,1,1,0,8));

        // bne with zero set: not taken.
        applyStimulus(0, 6'b000101, 1, 1);
        checkOutput("bne.fetch", outVec, pack(1,0,0,1,1,0,0,0,0,0,1,0,1,0,0));
        applyStimulus(0, 6'b000101, 1, 1);
        applyStimulus(0, 6'b000101, 1, 1);
        checkOutput("bne.brex", outVec, pack(0,0,0,0,0,1,0,0,0,1,0,1,1,0,8));

        // R-type.
        applyStimulus(0, 6'b000000, 0, 1);
        applyStimulus(0, 6'b000000, 0, 1);
        checkOutput("rtype.decode", outVec, pack(0,0,0,0,0,0,0,0,0,0,3,0,1,0,1));
        applyStimulus(0, 6'b000000, 0, 1);
        checkOutput("rtype.ex", outVec, pack(0,0,0,0,0,0,0,0,0,1,0,2,1,0,6));
        applyStimulus(0, 6'b000000, 0, 1);
        checkOutput("rtype.wb", outVec, pack(0,0,0,0,0,0,1,1,0,0,0,0,1,0,7));

        // andi: zero-extended immediate.
        applyStimulus(0, 6'b001100, 0, 1);
        checkOutput("andi.fetch", outVec, pack(1,0,0,1,1,0,0,0,0,0,1,0,0,0,0));
        applyStimulus(0, 6'b001100, 0, 1);
        applyStimulus(0, 6'b001100, 0, 1);
        checkOutput("andi.immex", outVec, pack(0,0,0,0,0,0,0,0,0,1,2,3,0,0,9));
        applyStimulus(0, 6'b001100, 0, 1);
        checkOutput("andi.immwb", outVec, pack(0,0,0,0,0,0,1,0,0,0,0,0,0,0,10));

        // addi: sign-extended immediate.
        applyStimulus(0, 6'b001000, 0, 1);
        applyStimulus(0, 6'b001000, 0, 1);
        applyStimulus(0, 6'b001000, 0, 1);
        checkOutput("addi.immex", outVec, pack(0,0,0,0,0,0,0,0,0,1,2,3,1,0,9));
        applyStimulus(0, 6'b001000, 0, 1);

        // Jump.
        applyStimulus(0, 6'b000010, 0, 1);
        applyStimulus(0, 6'b000010, 0, 1);
        applyStimulus(0, 6'b000010, 0, 1);
        checkOutput("j.jmp", outVec, pack(0,0,0,0,1,2,0,0,0,0,0,0,1,0,11));

        // Unknown opcode: illegal pulse in DECODE, then straight back to FETCH.
        applyStimulus(0, 6'b111111, 0, 1);
        checkOutput("ill.fetch", outVec, pack(1,0,0,1,1,0,0,0,0,0,1,0,1,0,0));
        applyStimulus(0, 6'b111111, 0, 1);
        checkOutput("ill.decode", outVec, pack(0,0,0,0,0,0,0,0,0,0,3,0,1,1,1));
        applyStimulus(0, 6'b111111, 0, 0);
        checkOutput("ill.back", outVec, pack(1,0,0,0,0,0,0,0,0,0,1,0,1,0,0));

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
